// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes,
// FSM state encoding and the control-code legality check.
package alu_share_arbiter_pkg;

    localparam int CTL_CODE_W = 4;

    localparam logic [CTL_CODE_W-1:0] CTL_AND = 4'b0000;
    localparam logic [CTL_CODE_W-1:0] CTL_OR  = 4'b0001;
    localparam logic [CTL_CODE_W-1:0] CTL_ADD = 4'b0010;
    localparam logic [CTL_CODE_W-1:0] CTL_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the code is one the shared ALU implements.
    function automatic logic ctrl_is_legal(input logic [CTL_CODE_W-1:0] i_code);
        return (i_code == CTL_AND) || (i_code == CTL_OR) ||
               (i_code == CTL_ADD) || (i_code == CTL_SUB);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant. When both inputs request, the port that
// did not win last time is chosen; otherwise the lone requester wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic       o_grant_vld,
    output logic       o_grant
);

    // Pick the winning port index from the request mask and last winner.
    always_comb begin
        o_grant_vld = |i_valid;
        if (&i_valid) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_valid[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. One transaction is
// in flight at a time: IDLE accepts and registers operands, EXEC captures
// the ALU output, RESP holds the result until the owning port takes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [CTRL_W-1:0] req_ctrl1,
    input  logic [XLEN-1:0]   req_a0,
    input  logic [XLEN-1:0]   req_a1,
    input  logic [XLEN-1:0]   req_b0,
    input  logic [XLEN-1:0]   req_b1,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_illegal;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [XLEN-1:0]   r_alu_a;
    logic [XLEN-1:0]   r_alu_b;
    logic [1:0]        r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_err;

    logic              w_grant_vld;
    logic              w_grant;
    logic              w_accept;
    logic [CTRL_W-1:0] w_sel_ctrl;
    logic [XLEN-1:0]   w_sel_a;
    logic [XLEN-1:0]   w_sel_b;

    rr_arb2 u_rr_arb2 (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_vld  (w_grant_vld),
        .o_grant      (w_grant)
    );

    // Operand mux and accept strobe; ready is held low while reset is asserted.
    always_comb begin
        w_sel_ctrl = w_grant ? req_ctrl1 : req_ctrl0;
        w_sel_a    = w_grant ? req_a1    : req_a0;
        w_sel_b    = w_grant ? req_b1    : req_b0;
        w_accept   = (r_state == ST_IDLE) && w_grant_vld && !reset;
        req_ready  = 2'b00;
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    // Transaction sequencer with registered ALU operands and response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_illegal    <= 1'b0;
            r_alu_ctrl   <= CTRL_W'(CTL_ADD);
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_alu_ctrl <= w_sel_ctrl;
                        r_alu_a    <= w_sel_a;
                        r_alu_b    <= w_sel_b;
                        r_grant    <= w_grant;
                        r_illegal  <= !ctrl_is_legal(w_sel_ctrl);
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // An illegal code still completes, but never exposes ALU output.
                    if (r_illegal) begin
                        r_rsp_data <= '0;
                        r_rsp_zero <= 1'b0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_rsp_data <= alu_result;
                        r_rsp_zero <= alu_zero;
                        r_rsp_err  <= 1'b0;
                    end
                    r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid  <= 2'b00;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_ctrl  = r_alu_ctrl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;

endmodule
